mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single CPU memory port between instruction fetch (IF) and data access (EX/MEM).
//  Arbitrates and registers one request at a time, then holds it on the port until Address_Ready.
//  Records each outstanding read's requester in an in-order tag FIFO.
//  Routes each Read_data beat back to the requester recorded at the FIFO head.
// PARAMETERS
//  OUTSTANDING  4  max issued-but-unanswered reads (tag FIFO depth, power of 2, >=2)
//  STARVE_MAX   4  consecutive data grants allowed while IF waits before IF is forced a grant
// PORTS
//  clk              in   1   clock
//  rst              in   1   synchronous, active-high reset
//  inst_req_valid   in   1   IF read request
//  inst_req_addr    in   32  IF word address
//  inst_req_ready   out  1   IF request accepted this cycle
//  inst_resp_data   out  32  fetched word
//  inst_resp_valid  out  1   fetched word valid
//  inst_resp_ready  in   1   IF consumes word
//  data_req_valid   in   1   data request
//  data_req_wen     in   1   1=store, 0=load
//  data_req_strb    in   4   store byte strobes
//  data_req_addr    in   32  data address
//  data_req_wdata   in   32  store data
//  data_req_ready   out  1   data request accepted this cycle
//  data_resp_data   out  32  raw load word (MEM stage extracts bytes/halves)
//  data_resp_valid  out  1   load word valid
//  data_resp_ready  in   1   MEM stage consumes word
//  Address          out  32  memory address
//  MemRead          out  1   read command
//  MemWrite         out  1   write command
//  Write_data       out  32  store data
//  Write_strb       out  4   store strobes
//  Address_Ready    in   1   memory accepts command
//  Read_data        in   32  memory read data
//  Read_data_Valid  in   1   read data valid
//  Read_data_Ready  out  1   read data consumed
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, starve_cnt=0, MemRead=MemWrite=0, all *_ready/*_valid outputs 0.
//   Exception: Read_data_Ready=1 while rst, to drain stale beats.
//  FSM IDLE -> CMD_I | CMD_D -> IDLE.
//  IDLE: a candidate is eligible if valid and (it is a store, or the FIFO is not full).
//   Data wins by default.
//   IF wins if starve_cnt==STARVE_MAX and IF is eligible.
//   IF also wins if it is the only eligible request.
//   Winner's *_req_ready=1 (combinational); the request is latched; go to CMD_I/CMD_D.
//   The loser's ready stays 0.
//   At most one accept per cycle; no accept outside IDLE.
//  starve_cnt:
//   +1 (saturating) on a data accept while inst_req_valid=1.
//   Cleared on an IF accept.
//   Cleared on any cycle with inst_req_valid=0.
//  CMD_x: MemRead/MemWrite, Address, Write_data and Write_strb are driven from the latch.
//   They are held stable until Address_Ready=1, then the FSM returns to IDLE.
//   Command is visible the cycle after accept; minimum 2 cycles per request.
//  Reads push the requester ID onto the FIFO in the accept cycle.
//   This reserves the slot, so the full check counts it.
//   Stores push nothing and never produce a response.
//  Responses, head ID = H, FIFO non-empty:
//   {inst|data}_resp_valid = Read_data_Valid & (H==ID).
//   *_resp_data = Read_data.
//   Read_data_Ready = ready of the selected requester.
//   Pop on Read_data_Valid & Read_data_Ready.
//  FIFO empty: Read_data_Ready=0 and both resp_valid=0; a beat here is a protocol error.
//  Simultaneous push+pop: allowed; count unchanged.
//   When full, a same-cycle pop does NOT unblock a push (eligibility uses the registered count).
//  Pointer wrap at OUTSTANDING is modulo.
//  Response delivery is independent of the FSM; a response can pop during CMD_x.
//  Reset mid-operation: the latched command is dropped (MemRead/MemWrite low the next cycle).
//   The FIFO is cleared; responses still in flight are drained by Read_data_Ready=1 during rst.
// STRUCTURE
//  mycpu.h: `REQ_ID_INST=1'b0, `REQ_ID_DATA=1'b1, FSM encodings `ARB_IDLE/`ARB_CMD_I/`ARB_CMD_D.
//  Sub-module resp_tag_fifo: 1-bit wide, depth OUTSTANDING.
//   Interface: push/pop/full/empty/head; synchronous reset.
//  Top level holds the FSM, request latch, starve counter and response mux.
// TESTING
//  1 IF-only read 0x100, Address_Ready after 2 cycles, Read_data=0xDEADBEEF
//    -> MemRead held 2 cycles, Address=0x100, inst_resp_valid with 0xDEADBEEF, data_resp_valid=0.
//  2 Both valid every cycle, STARVE_MAX=4, Address_Ready=1
//    -> grant order D,D,D,D,I,D,D,D,D,I; starve_cnt cleared after each IF grant.
//  3 Four loads issued, responses withheld -> 5th load: data_req_ready=0.
//    One response popped -> the load is accepted in the next IDLE cycle.
//  4 Load(data) then fetch(inst), responses 0x11, 0x22 in order
//    -> 0x11 on data_resp, 0x22 on inst_resp.
//    inst_resp_ready=0 while the head is inst -> Read_data_Ready=0 and the beat is held.
//  5 Store addr 0x204, strb 4'b0011, wdata 0xA5A5
//    -> MemWrite=1, Write_strb=0011, no FIFO push, a following load still gets its response.
//  6 rst asserted during CMD_D with 2 reads outstanding
//    -> next cycle MemRead=MemWrite=0, FIFO empty, Read_data_Ready=1 while rst.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the CPU memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned DEF_OUTSTANDING = 4;
    localparam int unsigned DEF_STARVE_MAX  = 4;
    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned STRB_W          = 4;

    localparam logic REQ_ID_INST = 1'b0;
    localparam logic REQ_ID_DATA = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_CMD_I = 2'd1,
        ARB_CMD_D = 2'd2
    } arb_state_e;

    // Latched memory command presented on the port while in CMD_x.
    typedef struct packed {
        logic              read;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
    } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-port signals of the arbiter.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic              inst_req_valid;
    logic [ADDR_W-1:0] inst_req_addr;
    logic              inst_req_ready;
    logic [DATA_W-1:0] inst_resp_data;
    logic              inst_resp_valid;
    logic              inst_resp_ready;

    logic              data_req_valid;
    logic              data_req_wen;
    logic [STRB_W-1:0] data_req_strb;
    logic [ADDR_W-1:0] data_req_addr;
    logic [DATA_W-1:0] data_req_wdata;
    logic              data_req_ready;
    logic [DATA_W-1:0] data_resp_data;
    logic              data_resp_valid;
    logic              data_resp_ready;

    logic [ADDR_W-1:0] Address;
    logic              MemRead;
    logic              MemWrite;
    logic [DATA_W-1:0] Write_data;
    logic [STRB_W-1:0] Write_strb;
    logic              Address_Ready;
    logic [DATA_W-1:0] Read_data;
    logic              Read_data_Valid;
    logic              Read_data_Ready;

    // Arbiter side.
    modport slave (
        input  inst_req_valid, inst_req_addr, inst_resp_ready,
        input  data_req_valid, data_req_wen, data_req_strb, data_req_addr, data_req_wdata,
        input  data_resp_ready,
        input  Address_Ready, Read_data, Read_data_Valid,
        output inst_req_ready, inst_resp_data, inst_resp_valid,
        output data_req_ready, data_resp_data, data_resp_valid,
        output Address, MemRead, MemWrite, Write_data, Write_strb, Read_data_Ready
    );

    // Requester/memory side.
    modport master (
        output inst_req_valid, inst_req_addr, inst_resp_ready,
        output data_req_valid, data_req_wen, data_req_strb, data_req_addr, data_req_wdata,
        output data_resp_ready,
        output Address_Ready, Read_data, Read_data_Valid,
        input  inst_req_ready, inst_resp_data, inst_resp_valid,
        input  data_req_ready, data_resp_data, data_resp_valid,
        input  Address, MemRead, MemWrite, Write_data, Write_strb, Read_data_Ready
    );

endinterface

// File: rtl/mem_port_arbiter_resp_tag_fifo.sv
// In-order FIFO of 1-bit requester IDs for outstanding reads.
module mem_port_arbiter_resp_tag_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Tag storage needs no reset; occupancy gates every read of it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_id;
    end

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned OUTSTANDING = DEF_OUTSTANDING,
    parameter int unsigned STARVE_MAX  = DEF_STARVE_MAX
) (
    input logic            clk,
    input logic            rst,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    arb_state_e          state_q, state_d;
    mem_cmd_t            cmd_q, cmd_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                inst_acc, data_acc;
    logic                inst_elig, data_elig, starved;
    logic                fifo_full, fifo_empty, fifo_head;
    logic                push, push_id, pop, resp_active;

    assign inst_elig = bus.inst_req_valid & ~fifo_full;
    assign data_elig = bus.data_req_valid & (bus.data_req_wen | ~fifo_full);
    assign starved   = (starve_q == STARVE_W'(STARVE_MAX));

    // State, command latch and starvation counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            cmd_q    <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            starve_q <= starve_d;
        end
    end

    // Arbitration in IDLE, command hold until the memory accepts it.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        inst_acc = 1'b0;
        data_acc = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (!rst) begin
                    if (data_elig && !(starved && inst_elig)) begin
                        data_acc = 1'b1;
                        cmd_d    = '{read:  ~bus.data_req_wen,
                                     write: bus.data_req_wen,
                                     addr:  bus.data_req_addr,
                                     wdata: bus.data_req_wdata,
                                     strb:  bus.data_req_strb};
                        state_d  = ARB_CMD_D;
                    end else if (inst_elig) begin
                        inst_acc = 1'b1;
                        cmd_d    = '{read:  1'b1,
                                     write: 1'b0,
                                     addr:  bus.inst_req_addr,
                                     wdata: '0,
                                     strb:  '0};
                        state_d  = ARB_CMD_I;
                    end
                end
            end
            ARB_CMD_I, ARB_CMD_D: begin
                if (bus.Address_Ready) begin
                    cmd_d.read  = 1'b0;
                    cmd_d.write = 1'b0;
                    state_d     = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Count data grants taken while IF keeps waiting.
    always_comb begin
        starve_d = starve_q;
        if (!bus.inst_req_valid || inst_acc) begin
            starve_d = '0;
        end else if (data_acc && !starved) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    assign push    = inst_acc | (data_acc & ~bus.data_req_wen);
    assign push_id = data_acc ? REQ_ID_DATA : REQ_ID_INST;
    assign pop     = bus.Read_data_Valid & bus.Read_data_Ready & resp_active;

    mem_port_arbiter_resp_tag_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .push_id (push_id),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    assign bus.inst_req_ready = inst_acc;
    assign bus.data_req_ready = data_acc;

    assign bus.MemRead    = cmd_q.read;
    assign bus.MemWrite   = cmd_q.write;
    assign bus.Address    = cmd_q.addr;
    assign bus.Write_data = cmd_q.wdata;
    assign bus.Write_strb = cmd_q.strb;

    // Response steering by the oldest outstanding requester; rst drains stale beats.
    assign resp_active         = ~rst & ~fifo_empty;
    assign bus.inst_resp_valid = resp_active & bus.Read_data_Valid & (fifo_head == REQ_ID_INST);
    assign bus.data_resp_valid = resp_active & bus.Read_data_Valid & (fifo_head == REQ_ID_DATA);
    assign bus.inst_resp_data  = bus.Read_data;
    assign bus.data_resp_data  = bus.Read_data;
    assign bus.Read_data_Ready = rst | (resp_active & ((fifo_head == REQ_ID_INST) ?
                                                       bus.inst_resp_ready : bus.data_resp_ready));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a queue-based reference model.
module tb_mem_port_arbiter;

    localparam int OUTS = 4;
    localparam int SMAX = 4;
    localparam int NCYC = 4000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .OUTSTANDING (OUTS),
        .STARVE_MAX  (SMAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model state: one pending command, queue of outstanding read owners.
    bit          busy;
    bit          m_rd, m_wr;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_strb;
    bit          tagq[$];
    int          starve;

    // Per-cycle stimulus and expectations.
    bit          iv, dv, wen, ar, rdv, irr, drr;
    logic [31:0] iaddr, daddr, wdata, rdata;
    logic [3:0]  strb;
    bit          elig_i, elig_d, g_i, g_d, e_rdr, e_iv, e_dv;
    int          pi [4] = '{70, 100, 50, 95};
    int          pd [4] = '{70, 100, 90, 60};
    int          pr [4] = '{70, 20, 90, 10};

    initial begin
        rst = 1'b1;
        bus.inst_req_valid  = 1'b0; bus.inst_req_addr  = '0; bus.inst_resp_ready = 1'b0;
        bus.data_req_valid  = 1'b0; bus.data_req_wen   = 1'b0; bus.data_req_strb = '0;
        bus.data_req_addr   = '0;   bus.data_req_wdata = '0;   bus.data_resp_ready = 1'b0;
        bus.Address_Ready   = 1'b0; bus.Read_data      = '0;   bus.Read_data_Valid = 1'b0;
        busy = 0; starve = 0; tagq.delete();
        @(posedge clk);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            int ph;
            @(posedge clk); #1;
            ph    = (cyc / 500) % 4;
            rst   = (cyc < 2) || ($urandom_range(0, 249) == 0);
            iv    = $urandom_range(0, 99) < pi[ph];
            dv    = $urandom_range(0, 99) < pd[ph];
            wen   = $urandom_range(0, 3) == 0;
            iaddr = $urandom; daddr = $urandom; wdata = $urandom; rdata = $urandom;
            strb  = 4'($urandom);
            ar    = $urandom_range(0, 99) < 60;
            irr   = $urandom_range(0, 99) < 80;
            drr   = $urandom_range(0, 99) < 80;
            rdv   = (rst || tagq.size() != 0) && ($urandom_range(0, 99) < pr[ph]);

            bus.inst_req_valid = iv;  bus.inst_req_addr = iaddr; bus.inst_resp_ready = irr;
            bus.data_req_valid = dv;  bus.data_req_wen = wen;    bus.data_req_strb = strb;
            bus.data_req_addr  = daddr; bus.data_req_wdata = wdata; bus.data_resp_ready = drr;
            bus.Address_Ready  = ar;  bus.Read_data = rdata;     bus.Read_data_Valid = rdv;

            // Expected grants from the arbitration rules.
            elig_i = iv && (tagq.size() < OUTS);
            elig_d = dv && (wen || tagq.size() < OUTS);
            g_d    = !rst && !busy && elig_d && !(starve == SMAX && elig_i);
            g_i    = !rst && !busy && !g_d && elig_i;

            // Expected response routing from the oldest outstanding owner.
            if (rst) begin
                e_rdr = 1; e_iv = 0; e_dv = 0;
            end else if (tagq.size() == 0) begin
                e_rdr = 0; e_iv = 0; e_dv = 0;
            end else begin
                e_rdr = (tagq[0] == 1'b0) ? irr : drr;
                e_iv  = rdv && (tagq[0] == 1'b0);
                e_dv  = rdv && (tagq[0] == 1'b1);
            end

            @(negedge clk);
            check_eq("inst_req_ready",  32'(bus.inst_req_ready),  32'(g_i));
            check_eq("data_req_ready",  32'(bus.data_req_ready),  32'(g_d));
            check_eq("MemRead",         32'(bus.MemRead),         32'(busy && m_rd));
            check_eq("MemWrite",        32'(bus.MemWrite),        32'(busy && m_wr));
            check_eq("Read_data_Ready", 32'(bus.Read_data_Ready), 32'(e_rdr));
            check_eq("inst_resp_valid", 32'(bus.inst_resp_valid), 32'(e_iv));
            check_eq("data_resp_valid", 32'(bus.data_resp_valid), 32'(e_dv));
            if (busy) check_eq("Address", bus.Address, m_addr);
            if (busy && m_wr) begin
                check_eq("Write_data", bus.Write_data, m_wdata);
                check_eq("Write_strb", 32'(bus.Write_strb), 32'(m_strb));
            end
            if (e_iv) check_eq("inst_resp_data", bus.inst_resp_data, rdata);
            if (e_dv) check_eq("data_resp_data", bus.data_resp_data, rdata);

            // Advance the model to the state after the coming clock edge.
            if (rst) begin
                busy = 0; starve = 0; tagq.delete();
            end else begin
                if (rdv && e_rdr && tagq.size() != 0) void'(tagq.pop_front());
                if (g_i || g_d) begin
                    busy   = 1;
                    m_rd   = g_i || !wen;
                    m_wr   = g_d && wen;
                    m_addr = g_i ? iaddr : daddr;
                    m_wdata = wdata;
                    m_strb = strb;
                    if (m_rd) tagq.push_back(g_d);
                end else if (busy && ar) begin
                    busy = 0;
                end
                if (!iv || g_i)                 starve = 0;
                else if (g_d && starve < SMAX)  starve++;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
